// File: rtl/mrd_pkg.sv
// Shared types and constants for the mixed-radix DFT factor/config generator.
package mrd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FACT,
        ST_DENOM,
        ST_DIV,
        ST_DONE
    } mrd_state_e;

    localparam logic [2:0] RDX_2 = 3'd2;
    localparam logic [2:0] RDX_3 = 3'd3;
    localparam logic [2:0] RDX_4 = 3'd4;
    localparam logic [2:0] RDX_5 = 3'd5;

    localparam int DEF_PTS_W       = 12;
    localparam int DEF_MAX_STAGES  = 6;
    localparam int DEF_RECIP_SHIFT = 19;
    localparam int DEF_RECIP_W     = 20;

    // stage_of_rdx2 value meaning "no radix-2 stage"
    localparam logic [2:0] RDX2_NONE = 3'd7;

endpackage

// File: rtl/mrd_factor_gen_if.sv
// Request/config bundle between the stream front end, the factor generator and the stage sequencer.
interface mrd_factor_gen_if
    import mrd_pkg::*;
#(
    parameter int PTS_W      = DEF_PTS_W,
    parameter int MAX_STAGES = DEF_MAX_STAGES,
    parameter int RECIP_W    = DEF_RECIP_W
);
    logic                                 start;
    logic [PTS_W-1:0]                     dftpts;
    logic                                 busy;
    logic                                 done;
    logic                                 err;
    logic                                 cfg_valid;
    logic [2:0]                           num_factors;
    logic [MAX_STAGES-1:0][2:0]           nf;
    logic [MAX_STAGES-1:0][PTS_W-1:0]     dftpts_div_nf;
    logic [MAX_STAGES-1:0][PTS_W-1:0]     twdl_demontr;
    logic [2:0]                           stage_of_rdx2;
    logic [MAX_STAGES-1:0][RECIP_W-1:0]   quotient;
    logic [MAX_STAGES-1:0][PTS_W-1:0]     remainder;

    modport master (
        output start, dftpts,
        input  busy, done, err, cfg_valid, num_factors, nf, dftpts_div_nf,
               twdl_demontr, stage_of_rdx2, quotient, remainder
    );

    modport slave (
        input  start, dftpts,
        output busy, done, err, cfg_valid, num_factors, nf, dftpts_div_nf,
               twdl_demontr, stage_of_rdx2, quotient, remainder
    );

endinterface

// File: rtl/mrd_seq_div.sv
// Restoring divider of the constant 2^RECIP_SHIFT by a PTS_W divisor, one quotient bit per cycle.
module mrd_seq_div
    import mrd_pkg::*;
#(
    parameter int PTS_W       = DEF_PTS_W,
    parameter int RECIP_SHIFT = DEF_RECIP_SHIFT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_i,
    input  logic [PTS_W-1:0]       divisor_i,
    output logic                   done_o,
    output logic [RECIP_SHIFT:0]   quotient_o,
    output logic [PTS_W-1:0]       remainder_o
);
    localparam int QW = RECIP_SHIFT + 1;
    localparam int CW = $clog2(RECIP_SHIFT + 1);

    logic             busy_q, busy_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PTS_W-1:0] dsr_q, dsr_d;
    logic [PTS_W-1:0] rem_q, rem_d;
    logic [QW-1:0]    quo_q, quo_d;

    logic [PTS_W:0]   rem_sh, rem_nxt;
    logic [QW-1:0]    quo_nxt;
    logic             ge, last;

    // Dividend is a single 1 followed by zeros, so only the first shifted-in bit is set.
    always_comb begin
        rem_sh  = {rem_q, (cnt_q == '0)};
        ge      = (rem_sh >= {1'b0, dsr_q});
        rem_nxt = ge ? (rem_sh - {1'b0, dsr_q}) : rem_sh;
        quo_nxt = {quo_q[QW-2:0], ge};
        last    = busy_q && (cnt_q == CW'(RECIP_SHIFT));
    end

    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        dsr_d  = dsr_q;
        rem_d  = rem_q;
        quo_d  = quo_q;
        if (busy_q) begin
            rem_d = rem_nxt[PTS_W-1:0];
            quo_d = quo_nxt;
            cnt_d = cnt_q + CW'(1);
            if (last) busy_d = 1'b0;
        end else if (start_i) begin
            busy_d = 1'b1;
            cnt_d  = '0;
            dsr_d  = divisor_i;
            rem_d  = '0;
            quo_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            dsr_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            dsr_q  <= dsr_d;
            rem_q  <= rem_d;
            quo_q  <= quo_d;
        end
    end

    // Results are presented during the final iteration so the caller can capture them that edge.
    assign done_o      = last;
    assign quotient_o  = quo_nxt;
    assign remainder_o = rem_nxt[PTS_W-1:0];

endmodule

// File: rtl/mrd_factor_gen.sv
// Factorises a DFT length into radix-4/2/3/5 stages and builds per-stage N/Nf, twiddle denominators and reciprocals.
module mrd_factor_gen
    import mrd_pkg::*;
#(
    parameter int PTS_W       = DEF_PTS_W,
    parameter int MAX_STAGES  = DEF_MAX_STAGES,
    parameter int RECIP_SHIFT = DEF_RECIP_SHIFT,
    parameter int RECIP_W     = DEF_RECIP_W
) (
    input  logic            clk,
    input  logic            rst_n,
    mrd_factor_gen_if.slave bus
);
    mrd_state_e state_q, state_d;
    logic [PTS_W-1:0] n_q, n_d;
    logic [PTS_W-1:0] r_q, r_d;
    logic [2:0]       k_q, k_d;
    logic [2:0]       j_q, j_d;
    logic [PTS_W-1:0] prod_q, prod_d;
    logic             div_run_q, div_run_d;
    logic             err_q, err_d;
    logic             cfg_valid_q, cfg_valid_d;
    logic [2:0]       num_factors_q, num_factors_d;
    logic [2:0]       rdx2_q, rdx2_d;

    logic [MAX_STAGES-1:0][2:0]         nf_q, nf_d;
    logic [MAX_STAGES-1:0][PTS_W-1:0]   div_nf_q, div_nf_d;
    logic [MAX_STAGES-1:0][PTS_W-1:0]   demontr_q, demontr_d;
    logic [MAX_STAGES-1:0][RECIP_W-1:0] quo_q, quo_d;
    logic [MAX_STAGES-1:0][PTS_W-1:0]   rem_q, rem_d;

    logic [2:0]         radix;
    logic [PTS_W-1:0]   n_div, r_div, prod;
    logic               div_start, div_done;
    logic [RECIP_SHIFT:0] div_quo;
    logic [PTS_W-1:0]   div_rem;

    // 4 is tried before 2 so at most one radix-2 stage can ever appear.
    always_comb begin
        radix = '0;
        if (r_q[1:0] == 2'b00)                radix = RDX_4;
        else if (!r_q[0])                     radix = RDX_2;
        else if (r_q % PTS_W'(3) == '0)       radix = RDX_3;
        else if (r_q % PTS_W'(5) == '0)       radix = RDX_5;
    end

    always_comb begin
        n_div = '0;
        r_div = '0;
        case (radix)
            RDX_4: begin n_div = n_q >> 2;        r_div = r_q >> 2;        end
            RDX_2: begin n_div = n_q >> 1;        r_div = r_q >> 1;        end
            RDX_3: begin n_div = n_q / PTS_W'(3); r_div = r_q / PTS_W'(3); end
            RDX_5: begin n_div = n_q / PTS_W'(5); r_div = r_q / PTS_W'(5); end
            default: ;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        n_d           = n_q;
        r_d           = r_q;
        k_d           = k_q;
        j_d           = j_q;
        prod_d        = prod_q;
        div_run_d     = div_run_q;
        err_d         = err_q;
        cfg_valid_d   = cfg_valid_q;
        num_factors_d = num_factors_q;
        rdx2_d        = rdx2_q;
        nf_d          = nf_q;
        div_nf_d      = div_nf_q;
        demontr_d     = demontr_q;
        quo_d         = quo_q;
        rem_d         = rem_q;
        div_start     = 1'b0;
        prod          = '0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    n_d           = bus.dftpts;
                    r_d           = bus.dftpts;
                    k_d           = '0;
                    j_d           = '0;
                    err_d         = 1'b0;
                    cfg_valid_d   = 1'b0;
                    num_factors_d = '0;
                    rdx2_d        = RDX2_NONE;
                    nf_d          = '0;
                    div_nf_d      = '0;
                    demontr_d     = '0;
                    quo_d         = '0;
                    rem_d         = '0;
                    state_d       = ST_FACT;
                end
            end

            ST_FACT: begin
                if (r_q == PTS_W'(1) && k_q != '0) begin
                    j_d     = k_q - 3'd1;
                    state_d = ST_DENOM;
                end else if (k_q == 3'(MAX_STAGES) || (r_q <= PTS_W'(1) && k_q == '0)
                             || radix == '0) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    nf_d[k_q]     = radix;
                    div_nf_d[k_q] = n_div;
                    r_d           = r_div;
                    k_d           = k_q + 3'd1;
                    if (radix == RDX_2) rdx2_d = k_q;
                end
            end

            // Suffix product built back to front; the full product equals N so it never overflows.
            ST_DENOM: begin
                if (j_q == k_q - 3'd1) prod = PTS_W'(nf_q[j_q]);
                else                   prod = prod_q * PTS_W'(nf_q[j_q]);
                demontr_d[j_q] = prod;
                prod_d         = prod;
                if (j_q == '0) begin
                    div_run_d = 1'b0;
                    state_d   = ST_DIV;
                end else begin
                    j_d = j_q - 3'd1;
                end
            end

            ST_DIV: begin
                if (!div_run_q) begin
                    div_start = 1'b1;
                    div_run_d = 1'b1;
                end else if (div_done) begin
                    quo_d[j_q] = RECIP_W'(div_quo);
                    rem_d[j_q] = div_rem;
                    div_run_d  = 1'b0;
                    if (j_q == k_q - 3'd1) begin
                        cfg_valid_d   = 1'b1;
                        num_factors_d = k_q;
                        state_d       = ST_DONE;
                    end else begin
                        j_d = j_q + 3'd1;
                    end
                end
            end

            ST_DONE: state_d = ST_IDLE;

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            n_q           <= '0;
            r_q           <= '0;
            k_q           <= '0;
            j_q           <= '0;
            prod_q        <= '0;
            div_run_q     <= 1'b0;
            err_q         <= 1'b0;
            cfg_valid_q   <= 1'b0;
            num_factors_q <= '0;
            rdx2_q        <= RDX2_NONE;
            nf_q          <= '0;
            div_nf_q      <= '0;
            demontr_q     <= '0;
            quo_q         <= '0;
            rem_q         <= '0;
        end else begin
            state_q       <= state_d;
            n_q           <= n_d;
            r_q           <= r_d;
            k_q           <= k_d;
            j_q           <= j_d;
            prod_q        <= prod_d;
            div_run_q     <= div_run_d;
            err_q         <= err_d;
            cfg_valid_q   <= cfg_valid_d;
            num_factors_q <= num_factors_d;
            rdx2_q        <= rdx2_d;
            nf_q          <= nf_d;
            div_nf_q      <= div_nf_d;
            demontr_q     <= demontr_d;
            quo_q         <= quo_d;
            rem_q         <= rem_d;
        end
    end

    mrd_seq_div #(
        .PTS_W       (PTS_W),
        .RECIP_SHIFT (RECIP_SHIFT)
    ) u_div (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (div_start),
        .divisor_i   (demontr_q[j_q]),
        .done_o      (div_done),
        .quotient_o  (div_quo),
        .remainder_o (div_rem)
    );

    assign bus.busy          = (state_q != ST_IDLE);
    assign bus.done          = (state_q == ST_DONE);
    assign bus.err           = err_q;
    assign bus.cfg_valid     = cfg_valid_q;
    assign bus.num_factors   = num_factors_q;
    assign bus.nf            = nf_q;
    assign bus.dftpts_div_nf = div_nf_q;
    assign bus.twdl_demontr  = demontr_q;
    assign bus.stage_of_rdx2 = rdx2_q;
    assign bus.quotient      = quo_q;
    assign bus.remainder     = rem_q;

endmodule

// File: tb/tb_mrd_factor_gen.sv
// Randomised bench for mrd_factor_gen against a factor-list reference model.
module tb_mrd_factor_gen;
    import mrd_pkg::*;

    localparam int PTS_W = 12;
    localparam int MAXS  = 6;
    localparam int RS    = 19;
    localparam int RW    = 20;

    logic clk = 1'b0;
    logic rst_n;

    mrd_factor_gen_if #(.PTS_W(PTS_W), .MAX_STAGES(MAXS), .RECIP_W(RW)) bus ();

    mrd_factor_gen #(
        .PTS_W(PTS_W), .MAX_STAGES(MAXS), .RECIP_SHIFT(RS), .RECIP_W(RW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // scratch model result, and the result the DUT is currently expected to hold
    int     s_nf[MAXS], s_dn[MAXS], s_dm[MAXS], s_r[MAXS];
    longint s_q[MAXS];
    int     s_err, s_num, s_rdx2, s_lat;
    int     m_nf[MAXS], m_dn[MAXS], m_dm[MAXS], m_r[MAXS];
    longint m_q[MAXS];
    int     m_err, m_cfg, m_num, m_rdx2, m_lat;

    bit m_active = 0;
    bit chk_en   = 0;
    int m_cyc    = 0;

    task automatic chk(input string name, input logic [63:0] act, input longint exp);
        total++;
        if (act !== 64'(exp)) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic model(input int n);
        int r, f, dec, rdx, p;
        r = n; f = 0; dec = 0; s_err = 0; s_rdx2 = 7;
        for (int i = 0; i < MAXS; i++) begin
            s_nf[i] = 0; s_dn[i] = 0; s_dm[i] = 0; s_q[i] = 0; s_r[i] = 0;
        end
        forever begin
            dec++;
            if (r == 1 && f >= 1) break;
            if (f == MAXS || (r <= 1 && f == 0)) begin s_err = 1; break; end
            if (r % 4 == 0)      rdx = 4;
            else if (r % 2 == 0) rdx = 2;
            else if (r % 3 == 0) rdx = 3;
            else if (r % 5 == 0) rdx = 5;
            else                 rdx = 0;
            if (rdx == 0) begin s_err = 1; break; end
            s_nf[f] = rdx;
            s_dn[f] = n / rdx;
            if (rdx == 2) s_rdx2 = f;
            r = r / rdx;
            f++;
        end
        if (!s_err) begin
            for (int i = 0; i < f; i++) begin
                p = 1;
                for (int k = i; k < f; k++) p = p * s_nf[k];
                s_dm[i] = p;
                s_q[i]  = (longint'(1) << RS) / p;
                s_r[i]  = int'((longint'(1) << RS) % p);
            end
        end
        s_num = s_err ? 0 : f;
        s_lat = s_err ? dec + 1 : 2 + f * (RS + 4);
    endtask

    task automatic commit();
        for (int i = 0; i < MAXS; i++) begin
            m_nf[i] = s_nf[i]; m_dn[i] = s_dn[i]; m_dm[i] = s_dm[i];
            m_q[i]  = s_q[i];  m_r[i]  = s_r[i];
        end
        m_err = s_err; m_cfg = !s_err; m_num = s_num; m_rdx2 = s_rdx2; m_lat = s_lat;
    endtask

    task automatic model_reset();
        for (int i = 0; i < MAXS; i++) begin
            m_nf[i] = 0; m_dn[i] = 0; m_dm[i] = 0; m_q[i] = 0; m_r[i] = 0;
        end
        m_err = 0; m_cfg = 0; m_num = 0; m_rdx2 = 7; m_lat = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".err"},  64'(bus.err),           longint'(m_err));
        chk({tag, ".cfg"},  64'(bus.cfg_valid),     longint'(m_cfg));
        chk({tag, ".num"},  64'(bus.num_factors),   longint'(m_num));
        chk({tag, ".rdx2"}, 64'(bus.stage_of_rdx2), longint'(m_rdx2));
        for (int i = 0; i < MAXS; i++) begin
            chk($sformatf("%s.nf[%0d]", tag, i),  64'(bus.nf[i]),            longint'(m_nf[i]));
            chk($sformatf("%s.div[%0d]", tag, i), 64'(bus.dftpts_div_nf[i]), longint'(m_dn[i]));
            chk($sformatf("%s.dm[%0d]", tag, i),  64'(bus.twdl_demontr[i]),  longint'(m_dm[i]));
            chk($sformatf("%s.q[%0d]", tag, i),   64'(bus.quotient[i]),      m_q[i]);
            chk($sformatf("%s.rem[%0d]", tag, i), 64'(bus.remainder[i]),     longint'(m_r[i]));
        end
    endtask

    // Single compare process: handshake every cycle, full result on done and while holding.
    always @(negedge clk) begin
        if (chk_en) begin
            if (m_active) begin
                m_cyc++;
                if (m_cyc < m_lat) begin
                    chk("run.busy", 64'(bus.busy), 1);
                    chk("run.done", 64'(bus.done), 0);
                    chk("run.cfg_valid", 64'(bus.cfg_valid), 0);
                end else begin
                    chk("done.busy", 64'(bus.busy), 1);
                    chk("done.pulse", 64'(bus.done), 1);
                    check_all("result");
                    m_active = 0;
                end
            end else begin
                chk("idle.busy", 64'(bus.busy), 0);
                chk("idle.done", 64'(bus.done), 0);
                check_all("hold");
            end
        end
    end

    task automatic launch(input int n);
        model(n);
        @(posedge clk); #2;
        bus.start  = 1'b1;
        bus.dftpts = PTS_W'(n);
        @(posedge clk); #1;
        bus.start  = 1'b0;
        bus.dftpts = PTS_W'($urandom);
        commit();
        m_cyc    = 0;
        m_active = 1;
    endtask

    // Pokes drive start while busy; the DONE cycle is always poked too.
    task automatic run(input int n, input bit pokes);
        launch(n);
        for (int c = 0; c < m_lat + 20; c++) begin
            @(posedge clk); #2;
            if (!m_active) break;
            bus.start  = (m_cyc + 1 == m_lat) || (pokes && $urandom_range(0, 5) == 0);
            bus.dftpts = PTS_W'($urandom);
        end
        bus.start = 1'b0;
        if (m_active) begin
            chk("timeout", 0, 1);
            m_active = 0;
        end
    endtask

    task automatic pin_model();
        int e_nf[5], e_dn[5], e_dm[5], e_q[5], e_r[5];
        e_nf = '{4, 4, 3, 5, 5};
        e_dn = '{300, 300, 400, 240, 240};
        e_dm = '{1200, 300, 75, 25, 5};
        e_q  = '{436, 1747, 6990, 20971, 104857};
        e_r  = '{1088, 188, 38, 13, 3};
        model(1200);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("pin1200.nf[%0d]", i), 64'(s_nf[i]), e_nf[i]);
            chk($sformatf("pin1200.div[%0d]", i), 64'(s_dn[i]), e_dn[i]);
            chk($sformatf("pin1200.dm[%0d]", i), 64'(s_dm[i]), e_dm[i]);
            chk($sformatf("pin1200.q[%0d]", i), 64'(s_q[i]), e_q[i]);
            chk($sformatf("pin1200.rem[%0d]", i), 64'(s_r[i]), e_r[i]);
        end
        chk("pin1200.lat", 64'(s_lat), 117);
        chk("pin1200.rdx2", 64'(s_rdx2), 7);
        model(12);
        chk("pin12.q0", 64'(s_q[0]), 43690);
        chk("pin12.q1", 64'(s_q[1]), 174762);
        chk("pin12.rem0", 64'(s_r[0]), 8);
        chk("pin12.num", 64'(s_num), 2);
        model(1536);
        chk("pin1536.rdx2", 64'(s_rdx2), 4);
        chk("pin1536.num", 64'(s_num), 6);
        model(2187);
        chk("pin2187.err", 64'(s_err), 1);
        model(7);
        chk("pin7.lat", 64'(s_lat), 2);
        model(0);
        chk("pin0.lat", 64'(s_lat), 2);
    endtask

    initial begin
        bus.start  = 1'b0;
        bus.dftpts = '0;
        rst_n      = 1'b1;
        model_reset();
        #1 rst_n = 1'b0;
        #22;
        chk("reset.busy", 64'(bus.busy), 0);
        check_all("reset");
        @(posedge clk); #3;
        rst_n  = 1'b1;
        chk_en = 1;

        pin_model();

        run(1200, 0);
        chk("lit1200.q0", 64'(bus.quotient[0]), 436);
        chk("lit1200.dm0", 64'(bus.twdl_demontr[0]), 1200);
        run(12, 1);
        run(1536, 1);
        chk("lit1536.rdx2", 64'(bus.stage_of_rdx2), 4);
        run(2187, 1);
        chk("lit2187.err", 64'(bus.err), 1);
        run(7, 0);
        run(0, 0);
        run(1, 1);

        // Asynchronous reset in the middle of the reciprocal phase.
        launch(1200);
        repeat (40) @(posedge clk);
        #3;
        m_active = 0;
        model_reset();
        rst_n = 1'b0;
        #1;
        chk("midrst.busy", 64'(bus.busy), 0);
        chk("midrst.rdx2", 64'(bus.stage_of_rdx2), 7);
        check_all("midrst");
        @(posedge clk); #3;
        rst_n = 1'b1;
        run(12, 0);
        chk("post_rst12.q1", 64'(bus.quotient[1]), 174762);

        for (int t = 0; t < 30; t++) begin
            int n, steps, x;
            if ($urandom_range(0, 2) == 0) begin
                n = int'($urandom_range(0, 4095));
            end else begin
                n = 1;
                steps = int'($urandom_range(1, 8));
                for (int s = 0; s < steps; s++) begin
                    case ($urandom_range(0, 3))
                        0:       x = 2;
                        1:       x = 3;
                        2:       x = 4;
                        default: x = 5;
                    endcase
                    if (n * x <= 4095) n = n * x;
                end
            end
            run(n, 1'($urandom_range(0, 1)));
        end

        repeat (3) @(posedge clk);
        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
